// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: reset vector, FSM encoding
// and the instruction field positions used for OP, branch immediate and jump target.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    localparam int OP_W    = 6;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int IMM_W   = 16;
    localparam int IMM_MSB = 15;
    localparam int TGT_W   = 26;
    localparam int TGT_MSB = 25;

    // Word-scaled, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_npc_calc.sv
// Combinational next-PC selection: jump beats a taken branch, which beats the
// sequential pc_plus4.
module npc_calc
    import inst_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [1:0]  Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] next_pc
);

    logic        taken;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Both branch bits set is a malformed decode and never redirects.
    assign taken = (Branch != 2'b11) & ((Branch[0] & Zero) | (Branch[1] & ~Zero));

    assign branch_target = pc_plus4 + branch_offset(instr[IMM_MSB:0]);
    assign jump_target   = {pc_plus4[31:28], instr[TGT_MSB:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests the word at pc, holds it for execute, and on
// commit advances pc (sequential, branch or jump) and counts the instruction.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     Branch,
    input  logic           Jump,
    input  logic           Zero,
    input  logic           commit,
    output logic           imem_req,
    output logic [31:0]    imem_addr,
    input  logic           imem_ack,
    input  logic [31:0]    imem_rdata,
    output logic [31:0]    instr,
    output logic [OP_W-1:0] OP,
    output logic           instr_valid,
    output logic [31:0]    pc,
    output logic [31:0]    pc_plus4,
    output logic [31:0]    instr_count
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic [31:0] next_pc;

    npc_calc u_npc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .Branch   (Branch),
        .Jump     (Jump),
        .Zero     (Zero),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_count_d = instr_count_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (commit) begin
                    instr_valid_d = 1'b0;
                    pc_d          = next_pc;
                    instr_count_d = instr_count_q + 32'd1;
                    state_d       = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered request follows the state it will be in next cycle.
        imem_req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign OP          = instr_q[OP_MSB:OP_LSB];
    assign instr_valid = instr_valid_q;
    assign instr_count = instr_count_q;

endmodule
